psum_ofifo: RTL
===============

# psum_ofifo

Output collection FIFO directly downstream of the systolic MAC array. It captures each column's partial sum when that column's valid bit fires. Columns drain at different cycles because the array's instruction skew staggers them, so every column has its own FIFO. A downstream consumer pops one complete row, one entry from every column, only when all columns hold data.

## Interface

Parameters:
- `psum_bw`, default 16, width of one partial sum, two's complement.
- `col`, default 8, number of array columns, equal to the number of column FIFOs.
- `depth`, default 16, entries per column FIFO; must be a power of two and at least 2.

Ports:
- `clk`, input, 1, single clock; all state updates on its rising edge.
- `reset`, input, 1, asynchronous, active-low; while low, all state is held at its reset value.
- `in`, input, psum_bw*col, MAC array south outputs; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
- `wr`, input, col, per-column push request, driven by the array's per-column valid.
- `rd`, input, 1, row pop request from the consumer.
- `out`, output, psum_bw*col, registered popped row, in the same column packing as `in`.
- `out_valid`, output, 1, registered; high for exactly one cycle after an accepted pop.
- `o_valid`, output, 1, high when every column FIFO holds at least one entry.
- `o_ready`, output, 1, high when no column FIFO is full.
- `o_full`, output, 1, high when any column FIFO is full; always equal to ~`o_ready`.
- `overflow`, output, 1, sticky error flag; set by a push to a full column.

## Operation

- Each column has its own read pointer and write pointer. Each pointer is $clog2(depth)+1 bits wide, with the extra bit used as a wrap bit.
- Column full: the pointers differ only in the wrap bit. Column empty: the pointers are equal.
- Push, per column c: if `wr[c]` is high and column c is not full, `in` slice c is written at its write pointer and the write pointer increments.
- Push to a full column: the data is dropped, the write pointer is unchanged, and `overflow` is set to 1. It stays 1 until reset.
- Pop: if `rd` and `o_valid` are both high, all column read pointers increment together. On the same edge, `out` is loaded with the head entry of every column and `out_valid` goes to 1.
- `rd` while `o_valid` is low: ignored. No pointer moves, `out` holds its value, and `out_valid` goes to 0.
- Full, empty, `o_valid`, `o_ready` and `o_full` are combinational decodes of the pointer registers. They reflect the state before the current edge.
- Simultaneous push and pop on a full column: the push is rejected and `overflow` is set. The pop proceeds.
- Simultaneous push and `rd` on an empty column: `o_valid` was low, so the pop is ignored and the push is accepted.
- Wrap-around: pointers roll over modulo 2*depth. Data order within each column is strictly FIFO.
- Columns are independent on the write side. A push on one column never affects another column's pointers.

## Timing

- Reset values: `out`=0, `out_valid`=0, `overflow`=0, all pointers 0. This gives `o_valid`=0, `o_ready`=1 and `o_full`=0.
- Push-to-visibility: a push accepted at edge N is reflected in `o_valid`/`o_full` during cycle N+1.
- Pop latency: an accepted pop at edge M presents data on `out` with `out_valid`=1 during cycle M+1.
- Back-to-back pops are supported every cycle while `o_valid` stays high.
- `out` holds its last popped value until the next accepted pop.
- Reset asserted mid-operation clears all stored data immediately and asynchronously. Operation resumes on the first rising edge after `reset` returns high.

## Configuration

- Macro `PSUM_OFIFO_RELU_EN`.
- Defined: each column slice loaded into `out` on a pop is passed through ReLU. A negative value (MSB = 1) is replaced by 0. Stored FIFO contents are not modified.
- Not defined: `out` carries the raw stored psums unchanged.

## Test plan

- Reset, then idle → `o_valid`=0, `o_ready`=1, `o_full`=0, `overflow`=0, `out`=0, `out_valid`=0.
- Skewed fill: `wr` = 8'b0000_0001, then 8'b0000_0011, and so on up to 8'hFF, one step per cycle, with column c carrying value c+1. `o_valid` rises only the cycle after column 7's first push. `rd` then returns `out` with column c = c+1 and `out_valid`=1 one cycle later.
- Fill column 0 with 16 pushes → `o_full`=1, `o_ready`=0. A 17th push sets `overflow`=1, and the stored data is unchanged on drain.
- Full pass through all columns: push 20 rows, popping continuously after the 4th, with ascending values per column. Pops return all 20 rows in order across pointer wrap, with no overflow.
- `rd` held high with column 3 empty → no pointer movement and `out_valid`=0. Pushing column 3 enables the pop on the following cycle.
- Reset pulsed low while 5 rows are stored → `o_valid`=0 immediately. With `PSUM_OFIFO_RELU_EN` defined, a later stored -3 pops as 0.

Source files
------------

// File: rtl/psum_ofifo_if.sv
// psum_ofifo_if: bus between the MAC array / consumer (master) and the column FIFO (slave).
//   in        : per-column partial sums, column c at [psum_bw*(c+1)-1 : psum_bw*c]
//   wr        : per-column push request
//   rd        : row pop request
//   out       : registered popped row, same packing as in
//   out_valid : one-cycle strobe after an accepted pop
//   o_valid   : every column holds data
//   o_ready   : no column full
//   o_full    : some column full
//   overflow  : sticky push-to-full error
interface psum_ofifo_if #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8
);
  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   out_valid;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_full;
  logic                   overflow;

  modport master (
    output in, wr, rd,
    input  out, out_valid, o_valid, o_ready, o_full, overflow
  );

  modport slave (
    input  in, wr, rd,
    output out, out_valid, o_valid, o_ready, o_full, overflow
  );
endinterface

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column output FIFOs behind the systolic MAC array. Each column
// pushes independently on its own valid bit; a row (one entry per column) pops
// only when every column holds data.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : psum_ofifo_if.slave (in, wr, rd, out, out_valid, o_valid, o_ready,
//           o_full, overflow)
// Optional feature: define PSUM_OFIFO_RELU_EN to clamp negative popped slices to 0.
module psum_ofifo #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned depth   = 16
) (
  input logic         clk,
  input logic         reset,
  psum_ofifo_if.slave bus
);
  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned pw = aw + 1;

  logic [psum_bw-1:0]     mem [col][depth];
  logic [pw-1:0]          wr_ptr [col];
  logic [pw-1:0]          rd_ptr [col];
  logic [col-1:0]         full;
  logic [col-1:0]         empty;
  logic [col-1:0]         push;
  logic                   all_valid;
  logic                   any_full;
  logic                   pop;
  logic [psum_bw*col-1:0] head_row;
  logic [psum_bw*col-1:0] out_q;
  logic                   out_valid_q;
  logic                   overflow_q;

  // Per-column status decoded from the pointer registers (pre-edge state).
  always_comb begin
    full  = '0;
    empty = '0;
    push  = '0;
    for (int unsigned c = 0; c < col; c++) begin
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      full[c]  = (wr_ptr[c] == {~rd_ptr[c][aw], rd_ptr[c][aw-1:0]});
      push[c]  = bus.wr[c] & ~full[c];
    end
  end

  assign all_valid = ~|empty;
  assign any_full  = |full;
  assign pop       = bus.rd & all_valid;

  // Head entry of every column, optionally rectified on the way out.
  always_comb begin
    logic [psum_bw-1:0] h;
    h        = '0;
    head_row = '0;
    for (int unsigned c = 0; c < col; c++) begin
      h = mem[c][rd_ptr[c][aw-1:0]];
`ifdef PSUM_OFIFO_RELU_EN
      if (h[psum_bw-1]) begin
        h = '0;
      end
`endif
      head_row[c*psum_bw +: psum_bw] = h;
    end
  end

  // Storage is not reset; validity comes only from the pointers.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < col; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c][aw-1:0]] <= bus.in[c*psum_bw +: psum_bw];
      end
    end
  end

  // Pointers, popped row register and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < col; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < col; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= wr_ptr[c] + pw'(1);
        end
        if (pop) begin
          rd_ptr[c] <= rd_ptr[c] + pw'(1);
        end
      end
      if (pop) begin
        out_q <= head_row;
      end
      out_valid_q <= pop;
      if (|(bus.wr & full)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.o_valid   = all_valid;
  assign bus.o_full    = any_full;
  assign bus.o_ready   = ~any_full;

endmodule
